// File: rtl/shift_sequencer.sv
// Multi-cycle variable left shifter: steps by 2 (or 1 for the odd tail) each clock.
// Optional sticky overflow output `ovf` is built only when SHIFT_OVF_EN is defined.
module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] entrada,
  input  logic [3:0]  amount,
  output logic        ready,
  output logic [15:0] saida,
  output logic        done
`ifdef SHIFT_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] saida_q, saida_d;
  logic [3:0]  rem_q, rem_d;
  logic [15:0] acc_step;
  logic [3:0]  rem_step;

`ifdef SHIFT_OVF_EN
  logic sticky_q, sticky_d;
  logic ovf_q, ovf_d;
  logic out_bits;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      saida_q <= '0;
`ifdef SHIFT_OVF_EN
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      saida_q <= saida_d;
`ifdef SHIFT_OVF_EN
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    acc_step = (rem_q >= 4'd2) ? (acc_q << 2) : (acc_q << 1);
    rem_step = (rem_q >= 4'd2) ? (rem_q - 4'd2) : 4'd0;
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    saida_d  = saida_q;
`ifdef SHIFT_OVF_EN
    // Bits lost off the top during this step, given the step size chosen above.
    out_bits = (rem_q >= 4'd2) ? (|acc_q[15:14]) : acc_q[15];
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = entrada;
          rem_d = amount;
`ifdef SHIFT_OVF_EN
          sticky_d = 1'b0;
`endif
          if (amount == 4'd0) begin
            state_d = DONE;
            saida_d = entrada;
`ifdef SHIFT_OVF_EN
            ovf_d = 1'b0;
`endif
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_step;
        rem_d = rem_step;
`ifdef SHIFT_OVF_EN
        sticky_d = sticky_q | out_bits;
`endif
        if (rem_step == 4'd0) begin
          state_d = DONE;
          saida_d = acc_step;
`ifdef SHIFT_OVF_EN
          ovf_d = sticky_q | out_bits;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign saida = saida_q;
`ifdef SHIFT_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized operations
// compared against an arithmetic model ((entrada << amount) mod 2^16, ceil(amount/2) steps).
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] entrada;
  logic [3:0]  amount;
  logic        ready;
  logic [15:0] saida;
  logic        done;
`ifdef SHIFT_OVF_EN
  logic        ovf;
  logic        ovf_model;
`endif

  int unsigned checks;
  int unsigned errors;
  logic [15:0] saida_model;

  shift_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .entrada (entrada),
    .amount  (amount),
    .ready   (ready),
    .saida   (saida),
    .done    (done)
`ifdef SHIFT_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_pre", {31'd0, ready}, 32'd1);
  endtask

  // One operation; poke=1 pulses a second start while busy, which must be ignored.
  task automatic run_op(input logic [15:0] e, input logic [3:0] a, input bit poke);
    int          n;
    logic [31:0] wide;
    logic [15:0] exp_r;
    logic        exp_o;
    n     = (int'(a) + 1) / 2;
    wide  = {16'h0, e} << a;
    exp_r = wide[15:0];
    exp_o = |wide[31:16];
    @(negedge clk);
    wait_ready();
    start   = 1'b1;
    entrada = e;
    amount  = a;
    @(posedge clk);
    #1;
    start   = 1'b0;
    entrada = 16'($urandom);
    amount  = 4'($urandom);
    for (int j = 0; j <= n + 1; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (poke && j == 2) begin
        start   = 1'b1;
        entrada = 16'hAAAA;
        amount  = 4'd2;
      end
      if (poke && j == 3) start = 1'b0;
      chk("done",  {31'd0, done},  {31'd0, (j == n)});
      chk("ready", {31'd0, ready}, {31'd0, (j == n + 1)});
      if (j >= n) chk("saida", {16'd0, saida}, {16'd0, exp_r});
      else        chk("saida_hold", {16'd0, saida}, {16'd0, saida_model});
`ifdef SHIFT_OVF_EN
      if (j >= n) chk("ovf", {31'd0, ovf}, {31'd0, exp_o});
      else        chk("ovf_hold", {31'd0, ovf}, {31'd0, ovf_model});
`endif
    end
    start       = 1'b0;
    saida_model = exp_r;
`ifdef SHIFT_OVF_EN
    ovf_model   = exp_o;
`endif
  endtask

  initial begin
    logic [15:0] e;
    logic [31:0] w;
    checks      = 0;
    errors      = 0;
    saida_model = '0;
`ifdef SHIFT_OVF_EN
    ovf_model   = 1'b0;
`endif
    reset   = 1'b0;
    start   = 1'b0;
    entrada = '0;
    amount  = '0;
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_saida", {16'd0, saida}, 32'd0);
`ifdef SHIFT_OVF_EN
    chk("rst_ovf",   {31'd0, ovf},   32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    run_op(16'h0001, 4'd0,  1'b0);
    run_op(16'h0003, 4'd5,  1'b0);
    run_op(16'h8001, 4'd1,  1'b0);
    run_op(16'hFFFF, 4'd15, 1'b0);
    run_op(16'h0001, 4'd15, 1'b1);
    run_op(16'h1234, 4'd0,  1'b0);

    // Reset in the middle of a 12-bit shift.
    @(negedge clk);
    wait_ready();
    start   = 1'b1;
    entrada = 16'h00F1;
    amount  = 4'd12;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_ready", {31'd0, ready}, 32'd1);
    chk("mid_done",  {31'd0, done},  32'd0);
    chk("mid_saida", {16'd0, saida}, 32'd0);
`ifdef SHIFT_OVF_EN
    chk("mid_ovf",   {31'd0, ovf},   32'd0);
    ovf_model = 1'b0;
`endif
    saida_model = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst_done", {31'd0, done}, 32'd0);
    end
    run_op(16'h0005, 4'd4, 1'b0);

    // start held high with amount=2: accept, SHIFT, DONE, IDLE... period of 3.
    e = 16'($urandom);
    w = {16'h0, e} << 2;
    @(negedge clk);
    wait_ready();
    start   = 1'b1;
    entrada = e;
    amount  = 4'd2;
    @(posedge clk);
    #1;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      chk("b2b_done",  {31'd0, done},  {31'd0, (j % 3 == 1)});
      chk("b2b_ready", {31'd0, ready}, {31'd0, (j % 3 == 2)});
      if (j >= 1) chk("b2b_saida", {16'd0, saida}, {16'd0, w[15:0]});
    end
    start       = 1'b0;
    saida_model = w[15:0];
`ifdef SHIFT_OVF_EN
    ovf_model   = |w[31:16];
`endif

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(16'($urandom), 4'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
